data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the word-addressed data memory. Hits return read data combinationally in the same cycle. Read misses stall the pipeline while a 4-word line is refilled from data memory, one word per cycle. Stores always pass straight through to data memory and update the cache only on a hit.

---
 rtl/dcache_pkg.sv | 36 +++
 rtl/dcache_array.sv | 47 ++++
 rtl/data_cache.sv | 190 +++++++++++++++++++
 tb/tb_data_cache.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the data cache.
// Widths derive from the cache geometry parameters.
package dcache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int aw, input int sets,
                                     input int words);
        return aw - $clog2(sets) - $clog2(words) - 2;
    endfunction

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SETS       = 64;
    localparam int DEF_WORDS      = 4;
    localparam int DEF_TAG_W      =
        tag_width(DEF_ADDR_WIDTH, DEF_SETS, DEF_WORDS);

    typedef struct packed {
        logic [DEF_TAG_W-1:0]                    tag;
        logic                                    valid;
        logic [DEF_WORDS-1:0][DEF_DATA_WIDTH-1:0] words;
    } line_t;

endpackage

// File: rtl/dcache_array.sv
// Tag and data storage: combinational read, synchronous word write,
// separate tag write port. Contents are not reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 22,
    localparam int IDX_W = index_width(SETS),
    localparam int OFF_W = offset_width(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      rd_index,
    input  logic [OFF_W-1:0]      rd_offset,
    output logic [TAG_WIDTH-1:0]  rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  word_we,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [OFF_W-1:0]      wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tag_we,
    input  logic [IDX_W-1:0]      tag_index,
    input  logic [TAG_WIDTH-1:0]  tag_data
);

    logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];
    logic [TAG_WIDTH-1:0]  tag_q  [SETS];

    assign rd_data = data_q[{rd_index, rd_offset}];
    assign rd_tag  = tag_q[rd_index];

    // Word write from either a store hit or a refill beat.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    // Tag write when a refill completes.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[tag_index] <= tag_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Load misses stall while the line refills one word per cycle.
module data_cache
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic                  cpu_read_en_i,
    input  logic                  cpu_write_en_i,
    input  logic [DATA_WIDTH-1:0] cpu_write_data_i,
    output logic [DATA_WIDTH-1:0] cpu_read_data_o,
    output logic                  stall_o,
    input  logic                  invalidate_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_write_en_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    localparam int OFF_W = offset_width(WORDS_PER_LINE);
    localparam int IDX_W = index_width(SETS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, SETS, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q;
    logic [TAG_W-1:0]  rf_tag_q;
    logic [IDX_W-1:0]  rf_idx_q;
    logic [SETS-1:0]   valid_q;
    logic              replay_q;
    logic [31:0]       hit_cnt_q, miss_cnt_q;

    logic [OFF_W-1:0]  cpu_off;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic              addr_unused;

    logic [TAG_W-1:0]      arr_tag;
    logic [DATA_WIDTH-1:0] arr_data;
    logic                  hit;

    logic                  word_we;
    logic [IDX_W-1:0]      wr_idx;
    logic [OFF_W-1:0]      wr_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  tag_we;
    logic                  start_refill;
    logic                  refill_done;
    logic                  hit_inc;
    logic                  miss_inc;

    assign cpu_off     = cpu_addr_i[2 +: OFF_W];
    assign cpu_idx     = cpu_addr_i[2 + OFF_W +: IDX_W];
    assign cpu_tag     = cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign addr_unused = ^cpu_addr_i[1:0];

    assign hit = valid_q[cpu_idx] && (arr_tag == cpu_tag);

    assign cpu_read_data_o  = arr_data;
    assign mem_write_data_o = cpu_write_data_i;
    assign hit_count_o      = hit_cnt_q;
    assign miss_count_o     = miss_cnt_q;

    dcache_array #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_WIDTH     (DATA_WIDTH),
        .TAG_WIDTH      (TAG_W)
    ) u_array (
        .clk       (clk_i),
        .rd_index  (cpu_idx),
        .rd_offset (cpu_off),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .word_we   (word_we),
        .wr_index  (wr_idx),
        .wr_offset (wr_off),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .tag_index (rf_idx_q),
        .tag_data  (rf_tag_q)
    );

    // Next-state, memory-side outputs and array write controls.
    always_comb begin
        state_d        = state_q;
        stall_o        = 1'b0;
        mem_addr_o     = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_write_en_o = 1'b0;
        word_we        = 1'b0;
        wr_idx         = cpu_idx;
        wr_off         = cpu_off;
        wr_data        = cpu_write_data_i;
        tag_we         = 1'b0;
        start_refill   = 1'b0;
        refill_done    = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_write_en_i) begin
                    mem_write_en_o = 1'b1;
                    word_we        = hit;
                end else if (cpu_read_en_i) begin
                    if (hit) begin
                        // The load replayed after a refill is not a hit.
                        hit_inc = !replay_q;
                    end else begin
                        stall_o      = 1'b1;
                        miss_inc     = 1'b1;
                        start_refill = 1'b1;
                        state_d      = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_o    = 1'b1;
                mem_addr_o = {rf_tag_q, rf_idx_q, cnt_q, 2'b00};
                word_we    = 1'b1;
                wr_idx     = rf_idx_q;
                wr_off     = cnt_q;
                wr_data    = mem_read_data_i;
                if (cnt_q == LAST) begin
                    tag_we      = 1'b1;
                    refill_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, refill word counter and latched miss address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rf_tag_q <= '0;
            rf_idx_q <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            replay_q <= refill_done;
            if (start_refill) begin
                cnt_q    <= '0;
                rf_tag_q <= cpu_tag;
                rf_idx_q <= cpu_idx;
            end else if (state_q == REFILL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Valid bits: a line being refilled stays invalid until complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (refill_done) begin
            valid_q[rf_idx_q] <= 1'b1;
        end else if (state_q == IDLE && invalidate_i) begin
            valid_q <= '0;
        end else if (start_refill) begin
            valid_q[cpu_idx] <= 1'b0;
        end
    end

    // Load hit and miss performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_inc) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: cycle vector table plus
// hand-written reset-mid-refill and invalidate sequences.
module tb_data_cache;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        inval;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] hits;
    logic [31:0] misses;

    int n_chk  = 0;
    int n_fail = 0;

    data_cache dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cpu_addr_i       (cpu_addr),
        .cpu_read_en_i    (cpu_rd),
        .cpu_write_en_i   (cpu_wr),
        .cpu_write_data_i (cpu_wdata),
        .cpu_read_data_o  (cpu_rdata),
        .stall_o          (stall),
        .invalidate_i     (inval),
        .mem_addr_o       (mem_addr),
        .mem_write_en_o   (mem_we),
        .mem_write_data_o (mem_wdata),
        .mem_read_data_i  (mem_rdata),
        .hit_count_o      (hits),
        .miss_count_o     (misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory, hashed so 0x1xxxx/0x2xxxx/0x3xxxx lines do not alias.
    logic [31:0] mem [4096];

    function automatic logic [11:0] midx(input logic [31:0] a);
        return {a[17:16], a[11:2]};
    endfunction

    assign mem_rdata = mem[midx(mem_addr)];

    always @(negedge clk) begin
        if (mem_we) mem[midx(mem_addr)] = mem_wdata;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        mwe;
        logic [31:0] maddr;
        logic        chk;
        logic [31:0] rdata;
        int          hits;
        int          misses;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(
        input logic rd, input logic wr, input logic [31:0] addr,
        input logic [31:0] wdata, input logic st, input logic mwe,
        input logic [31:0] maddr, input logic chk,
        input logic [31:0] rdata, input int h, input int m);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.stall = st; v.mwe = mwe; v.maddr = maddr;
        v.chk = chk; v.rdata = rdata; v.hits = h; v.misses = m;
        tbl.push_back(v);
    endfunction

    // Load miss: detect cycle, four refill beats, replayed hit.
    function automatic void add_miss(
        input logic [31:0] a, input logic [31:0] rdata,
        input int h, input int m);
        add(1, 0, a, 0, 1, 0, a, 0, 0, h, m);
        for (int k = 0; k < 4; k++)
            add(1, 0, a, 0, 1, 0, a + 32'(4 * k), 0, 0, h, m + 1);
        add(1, 0, a, 0, 0, 0, a, 1, rdata, h, m + 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic inv);
        @(posedge clk);
        #1;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = a;
        cpu_wdata = wd; inval = inv;
        #3;
    endtask

    // Hold a load until stall drops; returns the stalled cycle count.
    task automatic run_load(input logic [31:0] a, output int n);
        n = 0;
        step(1, 0, a, 0, 0);
        while (stall && n < 20) begin
            n++;
            step(1, 0, a, 0, 0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000;
        mem[midx(32'h10000)] = 32'hDEADBEEF;
        mem[midx(32'h10004)] = 32'hA501_0004;
        mem[midx(32'h10008)] = 32'hA501_0008;
        mem[midx(32'h10400)] = 32'hA501_0400;
        mem[midx(32'h30000)] = 32'hA503_0000;
        mem[midx(32'h30004)] = 32'hA503_0004;

        add_miss(32'h10000, 32'hDEADBEEF, 0, 0);
        add(1, 0, 32'h10008, 0, 0, 0, 32'h10008, 1, 32'hA501_0008, 0, 1);
        add(0, 1, 32'h10004, 32'h12345678, 0, 1, 32'h10004, 0, 0, 1, 1);
        add(1, 0, 32'h10004, 0, 0, 0, 32'h10004, 1, 32'h12345678, 1, 1);
        add(0, 1, 32'h20000, 32'hCAFEF00D, 0, 1, 32'h20000, 0, 0, 2, 1);
        add_miss(32'h20000, 32'hCAFEF00D, 2, 1);
        add_miss(32'h10000, 32'hDEADBEEF, 2, 2);
        add(1, 0, 32'h10004, 0, 0, 0, 32'h10004, 1, 32'h12345678, 2, 3);
        add_miss(32'h10400, 32'hA501_0400, 3, 3);
        add_miss(32'h10000, 32'hDEADBEEF, 3, 4);
        add(1, 1, 32'h10008, 32'h55AA55AA, 0, 1, 32'h10008, 0, 0, 3, 5);
        add(1, 0, 32'h10008, 0, 0, 0, 32'h10008, 1, 32'h55AA55AA, 3, 5);
        add(0, 0, 32'h10008, 0, 0, 0, 32'h10008, 0, 0, 4, 5);

        rst_n = 1'b0; cpu_rd = 0; cpu_wr = 0; inval = 0;
        cpu_addr = 0; cpu_wdata = 0;
        #1;
        chk("rst stall", 32'(stall), 0);
        chk("rst mwe", 32'(mem_we), 0);
        chk("rst hits", hits, 0);
        chk("rst misses", misses, 0);
        cpu_wr = 1; cpu_addr = 32'h40006; cpu_wdata = 32'h1;
        #1;
        chk("rst wr mwe", 32'(mem_we), 1);
        chk("rst wr maddr", mem_addr, 32'h40004);
        @(posedge clk);
        #1;
        cpu_wr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 0);
            chk($sformatf("r%0d stall", i), 32'(stall), 32'(tbl[i].stall));
            chk($sformatf("r%0d mwe", i), 32'(mem_we), 32'(tbl[i].mwe));
            chk($sformatf("r%0d maddr", i), mem_addr, tbl[i].maddr);
            if (tbl[i].chk)
                chk($sformatf("r%0d rdata", i), cpu_rdata, tbl[i].rdata);
            chk($sformatf("r%0d hits", i), hits, 32'(tbl[i].hits));
            chk($sformatf("r%0d misses", i), misses, 32'(tbl[i].misses));
        end
        chk("mem 10004", mem[midx(32'h10004)], 32'h12345678);

        // Reset during the third refill beat.
        step(1, 0, 32'h30000, 0, 0);
        chk("rr miss stall", 32'(stall), 1);
        step(1, 0, 32'h30000, 0, 0);
        step(1, 0, 32'h30000, 0, 0);
        @(posedge clk);
        #1;
        chk("rr beat2 maddr", mem_addr, 32'h30008);
        chk("rr beat2 stall", 32'(stall), 1);
        rst_n = 1'b0; cpu_rd = 0;
        #1;
        chk("rr stall drop", 32'(stall), 0);
        chk("rr misses clr", misses, 0);
        chk("rr hits clr", hits, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_load(32'h30000, n);
        chk("rr stall cycles", 32'(n), 5);
        chk("rr rdata", cpu_rdata, 32'hA503_0000);
        chk("rr misses", misses, 1);
        chk("rr hits", hits, 0);

        // Invalidate alongside a hit: hit served, next load misses.
        step(1, 0, 32'h30004, 0, 1);
        chk("inv hit stall", 32'(stall), 0);
        chk("inv hit rdata", cpu_rdata, 32'hA503_0004);
        step(1, 0, 32'h30004, 0, 0);
        chk("inv miss stall", 32'(stall), 1);
        chk("inv hits", hits, 1);
        run_load(32'h30004, n);
        chk("inv refill cycles", 32'(n), 4);
        chk("inv rdata", cpu_rdata, 32'hA503_0004);
        chk("inv misses", misses, 2);
        step(0, 0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
